// File: rtl/lr35902_dbg_pkg.sv
// Shared definitions for the LR35902 debug bus-override stage.
`default_nettype none

package lr35902_dbg_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACC_MEM = 2'd1;
    localparam logic [1:0] ACC_INJ = 2'd2;

    localparam logic [7:0] C_IDLE_BUS  = 8'hFF;
    localparam int         C_CAP_DEPTH = 2;

    // Capture counter saturates rather than wrapping so the debugger can tell "many".
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lr35902_dbg_bus_inject.sv
// Bus override between the LR35902 core and the memory fabric: answers reads with
// debug data and captures writes on probe while the debug controller injects.
`default_nettype none

module lr35902_dbg_bus_inject
    import lr35902_dbg_pkg::*;
#(
    parameter int CAP_DEPTH = C_CAP_DEPTH
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        dbg_drv,
    input  logic [7:0]  dbg_data,
    input  logic [15:0] cpu_adr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic [15:0] mem_adr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic [7:0]  probe,
    output logic [7:0]  probe_hi,
    output logic [1:0]  cap_cnt
);

    logic [1:0]             r_state;
    logic [7:0]             r_inj_data;
    logic                   r_prev_inj;
    logic [8*CAP_DEPTH-1:0] r_cap;
    logic [1:0]             r_cap_cnt;

    logic w_strobe;
    logic w_start;
    logic w_inj;
    logic w_rd_only;

    assign w_strobe  = cpu_rd | cpu_wr;
    assign w_start   = w_strobe && (r_state == IDLE);
    assign w_rd_only = cpu_rd && !cpu_wr;
    // On the start cycle the decision comes straight from dbg_drv; afterwards from the FSM.
    assign w_inj     = w_start ? dbg_drv : (r_state == ACC_INJ);

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_strobe) r_state <= dbg_drv ? ACC_INJ : ACC_MEM;
                ACC_MEM,
                ACC_INJ: if (!w_strobe) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_inj_data <= C_IDLE_BUS;
            r_prev_inj <= 1'b0;
        end else if (w_start) begin
            r_inj_data <= dbg_data;
            r_prev_inj <= dbg_drv;
        end
    end

    // A fresh inject sequence is recognised by an injected read after a normal access.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_cap     <= '0;
            r_cap_cnt <= 2'd0;
        end else if (w_start && dbg_drv && cpu_wr) begin
            r_cap     <= {r_cap[8*CAP_DEPTH-9:0], cpu_dout};
            r_cap_cnt <= sat_inc2(r_cap_cnt);
        end else if (w_start && dbg_drv && w_rd_only && (r_cap_cnt != 2'd0) && !r_prev_inj) begin
            r_cap_cnt <= 2'd0;
        end
    end

    assign mem_adr  = cpu_adr;
    assign mem_dout = cpu_dout;
    assign mem_rd   = !reset && !w_inj && w_rd_only;
    assign mem_wr   = !reset && !w_inj && cpu_wr;

    always_comb begin
        cpu_din = C_IDLE_BUS;
        if (!reset && !(cpu_rd && cpu_wr)) begin
            if (w_inj) begin
                cpu_din = w_start ? dbg_data : r_inj_data;
            end else if (w_strobe || (r_state == ACC_MEM)) begin
                cpu_din = mem_din;
            end
        end
    end

    assign probe    = r_cap[7:0];
    assign probe_hi = r_cap[15:8];
    assign cap_cnt  = r_cap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lr35902_dbg_bus_inject.sv
// Bench for lr35902_dbg_bus_inject: directed vector table then random accesses vs. a reference model.
`default_nettype none

module tb_lr35902_dbg_bus_inject;

    logic        cpu_clk;
    logic        reset;
    logic        dbg_drv;
    logic [7:0]  dbg_data;
    logic [15:0] cpu_adr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic [15:0] mem_adr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic [7:0]  probe;
    logic [7:0]  probe_hi;
    logic [1:0]  cap_cnt;

    lr35902_dbg_bus_inject #(.CAP_DEPTH(2)) dut (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .dbg_drv  (dbg_drv),
        .dbg_data (dbg_data),
        .cpu_adr  (cpu_adr),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .mem_adr  (mem_adr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .probe    (probe),
        .probe_hi (probe_hi),
        .cap_cnt  (cap_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic        rst;
        logic        drv;
        logic [7:0]  ddata;
        logic [15:0] adr;
        logic        rd;
        logic        wr;
        logic [7:0]  dout;
        logic [7:0]  mdin;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic       chk_din;
        logic [7:0] din;
        logic       mrd;
        logic       mwr;
        logic [7:0] pr;
        logic [7:0] prh;
        logic [1:0] cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model, in terms of accesses rather than states
    bit         m_in_acc;
    bit         m_inj;
    bit         m_prev_inj;
    logic [7:0] m_data;
    logic [7:0] m_caps[$];
    int         m_cnt;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic drv, input logic [7:0] dd,
                                input logic [15:0] adr, input logic rd, input logic wr,
                                input logic [7:0] dout, input logic [7:0] mdin,
                                input logic cd, input logic [7:0] din, input logic mrd,
                                input logic mwr, input logic [7:0] pr, input logic [7:0] prh,
                                input logic [1:0] cnt);
        vec_t v;
        v.s.rst = rst; v.s.drv = drv; v.s.ddata = dd; v.s.adr = adr;
        v.s.rd = rd; v.s.wr = wr; v.s.dout = dout; v.s.mdin = mdin;
        v.chk_din = cd; v.din = din; v.mrd = mrd; v.mwr = mwr;
        v.pr = pr; v.prh = prh; v.cnt = cnt;
        return v;
    endfunction

    task automatic model_edge(input stim_t s);
        bit strobe;
        strobe = s.rd | s.wr;
        if (s.rst) begin
            m_in_acc = 0; m_inj = 0; m_prev_inj = 0; m_cnt = 0;
            m_caps.delete();
        end else if (!m_in_acc && strobe) begin
            if (s.drv && s.wr) begin
                m_caps.push_front(s.dout);
                if (m_caps.size() > 2) void'(m_caps.pop_back());
                m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
            end else if (s.drv && s.rd && m_cnt != 0 && !m_prev_inj) begin
                m_cnt = 0;
            end
            m_prev_inj = s.drv;
            m_inj      = s.drv;
            m_data     = s.ddata;
            m_in_acc   = 1;
        end else if (m_in_acc && !strobe) begin
            m_in_acc = 0;
        end
    endtask

    task automatic run_cycle(input stim_t s, input bit use_tab, input vec_t v, input int row);
        bit         strobe, start, inj, e_chk_din, chk_mrd;
        logic [7:0] e_din, e_pr, e_prh;
        logic       e_mrd, e_mwr;
        string      tag;
        reset = s.rst; dbg_drv = s.drv; dbg_data = s.ddata; cpu_adr = s.adr;
        cpu_rd = s.rd; cpu_wr = s.wr; cpu_dout = s.dout; mem_din = s.mdin;
        #3;
        strobe = s.rd | s.wr;
        start  = !m_in_acc && strobe;
        inj    = start ? s.drv : (m_in_acc && m_inj);
        e_mrd  = !s.rst && !inj && s.rd && !s.wr;
        e_mwr  = !s.rst && !inj && s.wr;
        e_chk_din = 1;
        e_din  = 8'hFF;
        if (s.rst || (s.rd && s.wr)) e_din = 8'hFF;
        else if (inj)                e_din = start ? s.ddata : m_data;
        else if (strobe)             e_din = s.mdin;
        else if (m_in_acc)           e_chk_din = 0;
        e_pr   = (m_caps.size() > 0) ? m_caps[0] : 8'h00;
        e_prh  = (m_caps.size() > 1) ? m_caps[1] : 8'h00;
        chk_mrd = !(s.rd && s.wr) || s.rst || inj;
        if (use_tab) begin
            tag = $sformatf("row%0d", row);
            if (v.chk_din) chk({tag, "_cpu_din"}, {8'h00, cpu_din}, {8'h00, v.din});
            chk({tag, "_mem_rd"},   {15'h0, mem_rd},   {15'h0, v.mrd});
            chk({tag, "_mem_wr"},   {15'h0, mem_wr},   {15'h0, v.mwr});
            chk({tag, "_probe"},    {8'h00, probe},    {8'h00, v.pr});
            chk({tag, "_probe_hi"}, {8'h00, probe_hi}, {8'h00, v.prh});
            chk({tag, "_cap_cnt"},  {14'h0, cap_cnt},  {14'h0, v.cnt});
        end else begin
            if (e_chk_din) chk("rnd_cpu_din", {8'h00, cpu_din}, {8'h00, e_din});
            if (chk_mrd)   chk("rnd_mem_rd", {15'h0, mem_rd}, {15'h0, e_mrd});
            chk("rnd_mem_wr",   {15'h0, mem_wr},   {15'h0, e_mwr});
            chk("rnd_probe",    {8'h00, probe},    {8'h00, e_pr});
            chk("rnd_probe_hi", {8'h00, probe_hi}, {8'h00, e_prh});
            chk("rnd_cap_cnt",  {14'h0, cap_cnt},  m_cnt[15:0]);
        end
        chk("mem_adr",  mem_adr, s.adr);
        chk("mem_dout", {8'h00, mem_dout}, {8'h00, s.dout});
        @(posedge cpu_clk);
        model_edge(s);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  tab[27];
        vec_t  v0;
        stim_t s;
        v0 = '0;
        m_in_acc = 0; m_inj = 0; m_prev_inj = 0; m_cnt = 0; m_data = 8'hFF;

        //            rst drv dd     adr       rd wr dout   mdin   cd din    mrd mwr pr     prh    cnt
        tab[0]  = mk(1, 0, 8'h00, 16'h0000, 1, 1, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        tab[1]  = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        tab[2]  = mk(0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 8'h5A, 1, 8'h5A, 1, 0, 8'h00, 8'h00, 0);
        tab[3]  = mk(0, 0, 8'h00, 16'hC000, 1, 0, 8'h00, 8'h5A, 1, 8'h5A, 1, 0, 8'h00, 8'h00, 0);
        tab[4]  = mk(0, 0, 8'h00, 16'hC000, 0, 0, 8'h00, 8'h5A, 0, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        tab[5]  = mk(0, 1, 8'h3E, 16'h0100, 1, 0, 8'h00, 8'hA5, 1, 8'h3E, 0, 0, 8'h00, 8'h00, 0);
        tab[6]  = mk(0, 0, 8'h77, 16'h0100, 1, 0, 8'h00, 8'hA5, 1, 8'h3E, 0, 0, 8'h00, 8'h00, 0);
        tab[7]  = mk(0, 0, 8'h77, 16'h0100, 1, 0, 8'h00, 8'hA5, 1, 8'h3E, 0, 0, 8'h00, 8'h00, 0);
        tab[8]  = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        tab[9]  = mk(0, 1, 8'h3E, 16'hFFFE, 0, 1, 8'h12, 8'h00, 1, 8'h3E, 0, 0, 8'h00, 8'h00, 0);
        tab[10] = mk(0, 1, 8'h3E, 16'hFFFE, 0, 1, 8'h99, 8'h00, 1, 8'h3E, 0, 0, 8'h12, 8'h00, 1);
        tab[11] = mk(0, 1, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h12, 8'h00, 1);
        tab[12] = mk(0, 1, 8'h3E, 16'hFFFD, 0, 1, 8'h34, 8'h00, 1, 8'h3E, 0, 0, 8'h12, 8'h00, 1);
        tab[13] = mk(0, 1, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h34, 8'h12, 2);
        tab[14] = mk(0, 1, 8'h3E, 16'hFFFC, 0, 1, 8'h56, 8'h00, 1, 8'h3E, 0, 0, 8'h34, 8'h12, 2);
        tab[15] = mk(0, 1, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h56, 8'h34, 3);
        tab[16] = mk(0, 1, 8'h3E, 16'hFFFB, 0, 1, 8'h78, 8'h00, 1, 8'h3E, 0, 0, 8'h56, 8'h34, 3);
        tab[17] = mk(0, 1, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h78, 8'h56, 3);
        tab[18] = mk(0, 0, 8'h00, 16'hD000, 0, 1, 8'hAA, 8'h11, 1, 8'h11, 0, 1, 8'h78, 8'h56, 3);
        tab[19] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h78, 8'h56, 3);
        tab[20] = mk(0, 1, 8'h42, 16'h0200, 1, 0, 8'h00, 8'h00, 1, 8'h42, 0, 0, 8'h78, 8'h56, 3);
        tab[21] = mk(0, 1, 8'h42, 16'h0200, 1, 0, 8'h00, 8'h00, 1, 8'h42, 0, 0, 8'h78, 8'h56, 0);
        tab[22] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h78, 8'h56, 0);
        tab[23] = mk(1, 1, 8'h3E, 16'hFFFC, 0, 1, 8'hC3, 8'h00, 1, 8'hFF, 0, 0, 8'h78, 8'h56, 0);
        tab[24] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        tab[25] = mk(0, 1, 8'h3E, 16'h8000, 1, 1, 8'h5C, 8'h22, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        tab[26] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h5C, 8'h00, 1);

        reset = 1; dbg_drv = 0; dbg_data = 0; cpu_adr = 0; cpu_rd = 0; cpu_wr = 0;
        cpu_dout = 0; mem_din = 0;
        @(posedge cpu_clk);
        #1;

        for (int i = 0; i < 27; i++) run_cycle(tab[i].s, 1'b1, tab[i], i);

        for (int a = 0; a < 400; a++) begin
            int gap, len, kind;
            logic [15:0] adr;
            gap  = $urandom_range(1, 2);
            len  = $urandom_range(1, 4);
            kind = $urandom_range(0, 4);
            adr  = 16'($urandom);
            for (int g = 0; g < gap; g++) begin
                s = '0;
                s.rst   = ($urandom_range(0, 39) == 0);
                s.drv   = 1'($urandom_range(0, 1));
                s.ddata = 8'($urandom);
                s.adr   = adr;
                s.mdin  = 8'($urandom);
                run_cycle(s, 1'b0, v0, 0);
            end
            for (int c = 0; c < len; c++) begin
                s.rst   = ($urandom_range(0, 39) == 0);
                s.drv   = 1'($urandom_range(0, 1));
                s.ddata = 8'($urandom);
                s.adr   = adr;
                s.rd    = (kind <= 1) || (kind == 4);
                s.wr    = (kind >= 2);
                s.dout  = 8'($urandom);
                s.mdin  = 8'($urandom);
                run_cycle(s, 1'b0, v0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
